// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, ALU
// operations, datapath select values and base opcodes.
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_R,
        CLS_I,
        CLS_BRANCH
    } alu_class_t;

    localparam logic [1:0] SRC1_PC     = 2'd0;
    localparam logic [1:0] SRC1_PC_OLD = 2'd1;
    localparam logic [1:0] SRC1_RS1    = 2'd2;

    localparam logic [1:0] SRC2_RS2    = 2'd0;
    localparam logic [1:0] SRC2_IMM    = 2'd1;
    localparam logic [1:0] SRC2_FOUR   = 2'd2;

    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEM     = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;
    localparam logic [1:0] RES_IMM     = 2'd3;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

    // funct3[2] picks the less-than flag over equality; funct3[0] negates.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [1:0] zero);
        return (funct3[2] ? zero[1] : zero[0]) ^ funct3[0];
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational mapping from instruction class and funct fields to ALU_ctrl.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output alu_op_t     alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (alu_class)
            CLS_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            CLS_R, CLS_I: begin
                case (funct3)
                    // Immediate forms have no subtract; bit 30 is part of the immediate.
                    3'd0:    alu_op = (alu_class == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'd1:    alu_op = ALU_SLL;
                    3'd2:    alu_op = ALU_SLT;
                    3'd3:    alu_op = ALU_SLTU;
                    3'd4:    alu_op = ALU_XOR;
                    3'd5:    alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'd6:    alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core; outputs are decoded from the
// current state, with memory handshake and branch outcome folded in.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [1:0]  zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_sel,
    output logic [1:0]  ALU_src1_sel,
    output logic [1:0]  ALU_src2_sel,
    output logic [3:0]  ALU_ctrl,
    output logic        illegal
);

    state_t     state;
    state_t     state_next;
    alu_class_t alu_class;
    alu_op_t    alu_op;

    alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_op    (alu_op)
    );

    assign ALU_ctrl = alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_sel      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        result_sel   = RES_ALUOUT;
        ALU_src1_sel = SRC1_PC;
        ALU_src2_sel = SRC2_RS2;
        alu_class    = CLS_ADD;
        illegal      = 1'b0;

        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem_req      = 1'b1;
                ALU_src2_sel = SRC2_FOUR;
                result_sel   = RES_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative PC_old + imm lands in ALUOut for branch/JAL targets.
                ALU_src1_sel = SRC1_PC_OLD;
                ALU_src2_sel = SRC2_IMM;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_next = S_MEM_ADR;
                    OPC_OP:              state_next = S_EXEC_R;
                    OPC_OP_IMM:          state_next = S_EXEC_I;
                    OPC_BRANCH:          state_next = S_BRANCH;
                    OPC_JAL:             state_next = S_JAL;
                    OPC_JALR:            state_next = S_JALR;
                    OPC_LUI:             state_next = S_LUI;
                    OPC_AUIPC:           state_next = S_AUIPC;
                    default:             state_next = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                ALU_src1_sel = SRC1_RS1;
                ALU_src2_sel = SRC2_IMM;
                state_next   = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_sel = RES_MEM;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                ALU_src1_sel = SRC1_RS1;
                ALU_src2_sel = SRC2_RS2;
                alu_class    = CLS_R;
                state_next   = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALU_src1_sel = SRC1_RS1;
                ALU_src2_sel = SRC2_IMM;
                alu_class    = CLS_I;
                state_next   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALU_src1_sel = SRC1_RS1;
                ALU_src2_sel = SRC2_RS2;
                alu_class    = CLS_BRANCH;
                pc_write     = branch_taken(funct3, zero);
                state_next   = S_FETCH;
            end
            S_JAL: begin
                // Target already in ALUOut; ALU forms the link address meanwhile.
                pc_write     = 1'b1;
                ALU_src1_sel = SRC1_PC_OLD;
                ALU_src2_sel = SRC2_FOUR;
                state_next   = S_ALU_WB;
            end
            S_JALR: begin
                ALU_src1_sel = SRC1_RS1;
                ALU_src2_sel = SRC2_IMM;
                result_sel   = RES_ALU;
                pc_write     = 1'b1;
                state_next   = S_LINK;
            end
            S_LINK: begin
                ALU_src1_sel = SRC1_PC_OLD;
                ALU_src2_sel = SRC2_FOUR;
                state_next   = S_ALU_WB;
            end
            S_LUI: begin
                result_sel = RES_IMM;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_AUIPC: begin
                ALU_src1_sel = SRC1_PC_OLD;
                ALU_src2_sel = SRC2_IMM;
                state_next   = S_ALU_WB;
            end
            S_TRAP: illegal = 1'b1;
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full output bundle against hand-derived vectors.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [1:0]  zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  result_sel;
    logic [1:0]  ALU_src1_sel;
    logic [1:0]  ALU_src2_sel;
    logic [3:0]  ALU_ctrl;
    logic        illegal;

    logic [16:0] outs;
    int tests;
    int fails;

    logic [16:0] e_zero, e_fetch, e_fwait, e_dec, e_wb;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .adr_sel      (adr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .result_sel   (result_sel),
        .ALU_src1_sel (ALU_src1_sel),
        .ALU_src2_sel (ALU_src2_sel),
        .ALU_ctrl     (ALU_ctrl),
        .illegal      (illegal)
    );

    assign outs = {mem_req, mem_we, adr_sel, ir_write, pc_write, reg_write,
                   result_sel, ALU_src1_sel, ALU_src2_sel, ALU_ctrl, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Order: mem_req mem_we adr_sel ir_write pc_write reg_write res src1 src2 alu illegal
    function automatic logic [16:0] o(input logic mq, input logic we, input logic as,
                                      input logic iw, input logic pw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] s1,
                                      input logic [1:0] s2, input logic [3:0] alu,
                                      input logic ill);
        return {mq, we, as, iw, pw, rw, rs, s1, s2, alu, ill};
    endfunction

    task automatic cyc(input logic rdy, input logic [1:0] z);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b11);
            tests++;
            if (outs !== e_zero) begin
                fails++;
                $display("FAIL reset_hold%0d: got %h expected %h", i, outs, e_zero);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        tests++;
        if (outs !== e_zero) begin
            fails++;
            $display("FAIL reset_release: got %h expected %h", outs, e_zero);
        end
    endtask

    task automatic test_add(input logic f7);
        logic [16:0] ev [4];
        logic [3:0]  alu;
        alu = f7 ? 4'd1 : 4'd0;
        set_instr(7'h33, 3'd0, f7);
        ev = '{e_fetch, e_dec, o(0,0,0,0,0,0,2'd0,2'd2,2'd0,alu,0), e_wb};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b00);
            tests++;
            if (outs !== ev[i]) begin
                fails++;
                $display("FAIL add_f7_%0d cyc%0d: got %h expected %h", f7, i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_load;
        logic [16:0] ev [9];
        logic        rd [9];
        logic [16:0] e_mrd;
        e_mrd = o(1,0,1,0,0,0,2'd0,2'd0,2'd0,4'd0,0);
        set_instr(7'h03, 3'd2, 1'b0);
        ev = '{e_fwait, e_fetch, e_dec, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,0),
               e_mrd, e_mrd, e_mrd, e_mrd, o(0,0,0,0,0,1,2'd1,2'd0,2'd0,4'd0,0)};
        rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cyc(rd[i], 2'b00);
            tests++;
            if (outs !== ev[i]) begin
                fails++;
                $display("FAIL load cyc%0d: got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_store;
        logic [16:0] ev [5];
        logic        rd [5];
        set_instr(7'h23, 3'd2, 1'b0);
        ev = '{e_fetch, e_dec, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,0),
               o(1,1,1,0,0,0,2'd0,2'd0,2'd0,4'd0,0), o(1,1,1,0,0,0,2'd0,2'd0,2'd0,4'd0,0)};
        rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cyc(rd[i], 2'b00);
            tests++;
            if (outs !== ev[i]) begin
                fails++;
                $display("FAIL store cyc%0d: got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_branch;
        logic [2:0]  f3 [5];
        logic [1:0]  z  [5];
        logic [16:0] eb [5];
        logic [16:0] ev [3];
        f3 = '{3'd1, 3'd1, 3'd6, 3'd7, 3'd4};
        z  = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        eb = '{o(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd1,0),
               o(0,0,0,0,1,0,2'd0,2'd2,2'd0,4'd1,0),
               o(0,0,0,0,1,0,2'd0,2'd2,2'd0,4'd6,0),
               o(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd6,0),
               o(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd5,0)};
        for (int k = 0; k < 5; k++) begin
            set_instr(7'h63, f3[k], 1'b0);
            ev = '{e_fetch, e_dec, eb[k]};
            for (int i = 0; i < 3; i++) begin
                cyc(1'b1, z[k]);
                tests++;
                if (outs !== ev[i]) begin
                    fails++;
                    $display("FAIL branch_f3_%0d cyc%0d: got %h expected %h", f3[k], i, outs, ev[i]);
                end
            end
        end
    endtask

    task automatic test_jumps;
        logic [16:0] ej [5];
        logic [16:0] ea [4];
        set_instr(7'h67, 3'd0, 1'b0);
        ej = '{e_fetch, e_dec, o(0,0,0,0,1,0,2'd2,2'd2,2'd1,4'd0,0),
               o(0,0,0,0,0,0,2'd0,2'd1,2'd2,4'd0,0), e_wb};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'b00);
            tests++;
            if (outs !== ej[i]) begin
                fails++;
                $display("FAIL jalr cyc%0d: got %h expected %h", i, outs, ej[i]);
            end
        end
        set_instr(7'h6F, 3'd0, 1'b0);
        ea = '{e_fetch, e_dec, o(0,0,0,0,1,0,2'd0,2'd1,2'd2,4'd0,0), e_wb};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b00);
            tests++;
            if (outs !== ea[i]) begin
                fails++;
                $display("FAIL jal cyc%0d: got %h expected %h", i, outs, ea[i]);
            end
        end
    endtask

    task automatic test_upper;
        logic [16:0] el [3];
        logic [16:0] ea [4];
        set_instr(7'h37, 3'd0, 1'b0);
        el = '{e_fetch, e_dec, o(0,0,0,0,0,1,2'd3,2'd0,2'd0,4'd0,0)};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b00);
            tests++;
            if (outs !== el[i]) begin
                fails++;
                $display("FAIL lui cyc%0d: got %h expected %h", i, outs, el[i]);
            end
        end
        set_instr(7'h17, 3'd0, 1'b0);
        ea = '{e_fetch, e_dec, o(0,0,0,0,0,0,2'd0,2'd1,2'd1,4'd0,0), e_wb};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b00);
            tests++;
            if (outs !== ea[i]) begin
                fails++;
                $display("FAIL auipc cyc%0d: got %h expected %h", i, outs, ea[i]);
            end
        end
    endtask

    task automatic test_op_imm;
        logic [2:0]  f3 [2];
        logic [3:0]  alu [2];
        logic [16:0] ev [4];
        f3  = '{3'd5, 3'd0};
        alu = '{4'd9, 4'd0};
        for (int k = 0; k < 2; k++) begin
            set_instr(7'h13, f3[k], 1'b1);
            ev = '{e_fetch, e_dec, o(0,0,0,0,0,0,2'd0,2'd2,2'd1,alu[k],0), e_wb};
            for (int i = 0; i < 4; i++) begin
                cyc(1'b1, 2'b00);
                tests++;
                if (outs !== ev[i]) begin
                    fails++;
                    $display("FAIL opimm_f3_%0d cyc%0d: got %h expected %h", f3[k], i, outs, ev[i]);
                end
            end
        end
    endtask

    task automatic test_trap;
        logic [16:0] ev [5];
        logic [16:0] et;
        et = o(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,1);
        set_instr(7'h7F, 3'd0, 1'b0);
        ev = '{e_fetch, e_dec, et, et, et};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'b00);
            tests++;
            if (outs !== ev[i]) begin
                fails++;
                $display("FAIL trap cyc%0d: got %h expected %h", i, outs, ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        tests++;
        if (outs !== e_zero) begin
            fails++;
            $display("FAIL reset_from_trap: got %h expected %h", outs, e_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (outs !== e_zero) begin
            fails++;
            $display("FAIL reset_release2: got %h expected %h", outs, e_zero);
        end
        set_instr(7'h33, 3'd0, 1'b0);
        cyc(1'b0, 2'b00);
        tests++;
        if (outs !== e_fwait) begin
            fails++;
            $display("FAIL fetch_wait: got %h expected %h", outs, e_fwait);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (outs !== e_zero) begin
            fails++;
            $display("FAIL reset_mid_fetch: got %h expected %h", outs, e_zero);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (outs !== e_zero) begin
            fails++;
            $display("FAIL reset_release3: got %h expected %h", outs, e_zero);
        end
        cyc(1'b1, 2'b00);
        tests++;
        if (outs !== e_fetch) begin
            fails++;
            $display("FAIL fetch_after_reset: got %h expected %h", outs, e_fetch);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        opcode    = 7'h00;
        funct3    = 3'd0;
        funct7_5  = 1'b0;
        zero      = 2'b00;
        mem_ready = 1'b0;
        e_zero  = '0;
        e_fetch = o(1,0,0,1,1,0,2'd2,2'd0,2'd2,4'd0,0);
        e_fwait = o(1,0,0,0,0,0,2'd2,2'd0,2'd2,4'd0,0);
        e_dec   = o(0,0,0,0,0,0,2'd0,2'd1,2'd1,4'd0,0);
        e_wb    = o(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,0);

        test_reset();
        test_add(1'b0);
        test_add(1'b1);
        test_load();
        test_store();
        test_branch();
        test_jumps();
        test_upper();
        test_op_imm();
        test_trap();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multicycle RV32I core: sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath select/enable, including the ALU source selects and operation code. Sits beside the ALU, register file and unified memory port; consumes the opcode/funct fields of the latched instruction and the ALU `zero` flags.

## Interface
- No parameters.
- `clk` in 1: single core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: instruction register [6:0].
- `funct3` in 3: instruction register [14:12].
- `funct7_5` in 1: instruction register bit 30.
- `zero` in 2: ALU flags; bit0 = operands equal, bit1 = src1 less than src2 (signed or unsigned per op).
- `mem_ready` in 1: memory completes current request this cycle.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: request is a store.
- `adr_sel` out 1: memory address, 0 = PC, 1 = ALUOut register.
- `ir_write` out 1: latch fetched word into IR and PC into PC_old.
- `pc_write` out 1: load PC from result bus.
- `reg_write` out 1: write result bus to rd.
- `result_sel` out 2: 0 = ALUOut, 1 = memory data, 2 = ALU_result, 3 = imm_ext.
- `ALU_src1_sel` out 2: 0 = PC, 1 = PC_old, 2 = rs1.
- `ALU_src2_sel` out 2: 0 = rs2, 1 = imm_ext, 2 = constant 4.
- `ALU_ctrl` out 4: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 signed compare, 6 unsigned compare, 7 sll, 8 srl, 9 sra.
- `illegal` out 1: unsupported opcode trapped.

## Operation
- Moore outputs decoded from state only (plus funct fields for ALU_ctrl/branch); all outputs 0 in states not listed as asserting them.
- IDLE: reset state, all outputs 0; next FETCH.
- FETCH: mem_req=1, adr_sel=0, src1=PC, src2=4, add, result_sel=2. Holds until mem_ready; on that cycle ir_write=1, pc_write=1 -> DECODE.
- DECODE: src1=PC_old, src2=imm, add (branch/jal target into ALUOut). Dispatch on opcode: load/store -> MEM_ADR; R-type -> EXEC_R; OP-IMM -> EXEC_I; branch -> BRANCH; JAL -> JAL; JALR -> JALR; LUI -> LUI; AUIPC -> AUIPC; other -> TRAP.
- MEM_ADR: src1=rs1, src2=imm, add -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, adr_sel=1; wait mem_ready -> MEM_WB. MEM_WB: result_sel=1, reg_write=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, adr_sel=1; wait mem_ready -> FETCH.
- EXEC_R: src1=rs1, src2=rs2, ALU_ctrl from funct3/funct7_5 -> ALU_WB. EXEC_I: src2=imm; funct7_5 selects sub only never (addi), sra vs srl for funct3=5 -> ALU_WB.
- ALU_WB: result_sel=0, reg_write=1 -> FETCH.
- BRANCH: src1=rs1, src2=rs2; beq/bne sub, use zero[0]; blt/bge op 5, bltu/bgeu op 6, use zero[1]; bne/bge/bgeu invert. Taken: pc_write=1, result_sel=0. -> FETCH.
- JAL: pc_write=1, result_sel=0; src1=PC_old, src2=4, add -> ALU_WB.
- JALR: src1=rs1, src2=imm, add, result_sel=2, pc_write=1 -> LINK. LINK: src1=PC_old, src2=4, add -> ALU_WB.
- LUI: result_sel=3, reg_write=1 -> FETCH. AUIPC: src1=PC_old, src2=imm, add -> ALU_WB.
- TRAP: illegal=1, sticky until reset.

## Timing
- rst_n low: state forced IDLE immediately; every output 0 while asserted and in first cycle after release.
- mem_req and its qualifiers held stable until mem_ready cycle; mem_ready outside a request state ignored.
- CPI with zero-wait memory: load 5, store 4, R/I/AUIPC 4, branch 3, JAL 4, JALR 5, LUI 3.
- Reset mid-request abandons request; memory must tolerate dropped mem_req.

## Structure
- `ctrl_pkg`: state enum, ALU op enum, src1/src2/result select constants, opcode constants; shared with ALU.
- Sub-module `alu_decoder`: combinational funct3/funct7_5/op-class -> ALU_ctrl.

## Test plan
- add x3,x1,x2 with mem_ready=1: FETCH,DECODE,EXEC_R,ALU_WB; reg_write high cycle 4, ALU_ctrl=1 only for sub variant.
- lw with mem_ready delayed 3 cycles in MEM_RD: mem_req/adr_sel=1 held 4 cycles, reg_write with result_sel=1 one cycle after ready.
- bne with zero=2'b01: pc_write=0; zero=2'b00: pc_write=1, result_sel=0.
- bltu: ALU_ctrl=6; zero[1]=1 -> pc_write=1; bgeu same flags -> pc_write=0.
- jalr: pc_write with result_sel=2, then LINK src1=1, src2=2, reg_write in ALU_WB.
- opcode 7'h7F -> TRAP, illegal=1 held; rst_n pulse mid-FETCH -> IDLE, outputs 0, illegal cleared.
